// File: rtl/axi_burst_counter_table.sv
// Per-ID AXI burst beat counter table with an age matrix so that same-ID bursts retire in allocation order.
// Optional per-burst sticky error flag is enabled by defining AXI_BURST_COUNTER_ERR_EN.
module axi_burst_counter_table #(
    parameter int MaxTxns  = 4,
    parameter int IdWidth  = 4,
    parameter int LenWidth = 8,
    parameter int FullBW   = 0
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [IdWidth-1:0]                alloc_id_i,
    input  logic [LenWidth-1:0]               alloc_len_i,
    input  logic                              alloc_req_i,
    output logic                              alloc_gnt_o,
    input  logic [IdWidth-1:0]                cnt_id_i,
    input  logic                              cnt_req_i,
    output logic                              cnt_gnt_o,
    output logic [LenWidth-1:0]               cnt_len_o,
    input  logic                              cnt_dec_i,
    input  logic                              cnt_set_err_i,
    output logic                              cnt_err_o,
    output logic [$clog2(MaxTxns+1)-1:0]      occ_o
);

    localparam int OccWidth = $clog2(MaxTxns + 1);
    localparam int RemWidth = LenWidth + 1;
    localparam int IdxWidth = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;

    // Handshakes: an allocation is taken when alloc_req_i && alloc_gnt_o; a lookup
    // is taken when cnt_req_i && cnt_gnt_o, and it only consumes a beat with cnt_dec_i.
    logic [MaxTxns-1:0]  valid_q, valid_d;
    logic [IdWidth-1:0]  id_q    [MaxTxns];
    logic [IdWidth-1:0]  id_d    [MaxTxns];
    logic [RemWidth-1:0] rem_q   [MaxTxns];
    logic [RemWidth-1:0] rem_d   [MaxTxns];
    // older_q[i][j] set means slot i was allocated before slot j.
    logic [MaxTxns-1:0]  older_q [MaxTxns];
    logic [MaxTxns-1:0]  older_d [MaxTxns];
    logic [OccWidth-1:0] occ_q, occ_d;

    logic [MaxTxns-1:0]  match;
    logic [MaxTxns-1:0]  head_blk;
    logic [MaxTxns-1:0]  head_vec;
    logic                head_found;
    logic [IdxWidth-1:0] head_idx;
    logic [RemWidth-1:0] head_rem;
    logic [RemWidth-1:0] len_m1;
    logic                lookup_hs;
    logic                dec_hs;
    logic                last_beat;
    logic [MaxTxns-1:0]  free_vec;
    logic [IdxWidth-1:0] alloc_idx;
    logic                alloc_hs;

    always_comb begin
        match    = '0;
        head_blk = '0;
        for (int i = 0; i < MaxTxns; i++) begin
            match[i] = valid_q[i] && (id_q[i] == cnt_id_i);
        end
        for (int i = 0; i < MaxTxns; i++) begin
            for (int j = 0; j < MaxTxns; j++) begin
                if (match[j] && older_q[j][i]) begin
                    head_blk[i] = 1'b1;
                end
            end
        end
        head_vec   = match & ~head_blk;
        head_found = |head_vec;
        head_idx   = '0;
        for (int i = MaxTxns - 1; i >= 0; i--) begin
            if (head_vec[i]) begin
                head_idx = IdxWidth'(i);
            end
        end
    end

    assign head_rem  = rem_q[head_idx];
    assign len_m1    = head_rem - RemWidth'(1);
    assign cnt_len_o = head_found ? len_m1[LenWidth-1:0] : '0;
    assign cnt_gnt_o = cnt_req_i && head_found;
    assign lookup_hs = cnt_gnt_o;
    assign dec_hs    = lookup_hs && cnt_dec_i;
    assign last_beat = dec_hs && (head_rem == RemWidth'(1));

    // With FullBW the slot retiring this cycle is offered straight back to allocation.
    always_comb begin
        free_vec = ~valid_q;
        if ((FullBW != 0) && last_beat) begin
            free_vec[head_idx] = 1'b1;
        end
        alloc_idx = '0;
        for (int i = MaxTxns - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                alloc_idx = IdxWidth'(i);
            end
        end
    end

    assign alloc_gnt_o = |free_vec;
    assign alloc_hs    = alloc_req_i && alloc_gnt_o;

`ifdef AXI_BURST_COUNTER_ERR_EN
    logic [MaxTxns-1:0] err_q, err_d;
    assign cnt_err_o = (head_found && err_q[head_idx]) || (lookup_hs && cnt_set_err_i);
`else
    logic err_unused;
    assign err_unused = cnt_set_err_i;
    assign cnt_err_o  = 1'b0;
`endif

    // Free is applied first so that an allocation into the same slot overrides it.
    always_comb begin
        valid_d = valid_q;
        id_d    = id_q;
        rem_d   = rem_q;
        older_d = older_q;
`ifdef AXI_BURST_COUNTER_ERR_EN
        err_d   = err_q;
        if (lookup_hs && cnt_set_err_i) begin
            err_d[head_idx] = 1'b1;
        end
`endif
        if (dec_hs) begin
            rem_d[head_idx] = len_m1;
        end
        if (last_beat) begin
            valid_d[head_idx] = 1'b0;
            older_d[head_idx] = '0;
            for (int j = 0; j < MaxTxns; j++) begin
                older_d[j][head_idx] = 1'b0;
            end
        end
        if (alloc_hs) begin
            valid_d[alloc_idx] = 1'b1;
            id_d[alloc_idx]    = alloc_id_i;
            rem_d[alloc_idx]   = {1'b0, alloc_len_i} + RemWidth'(1);
            older_d[alloc_idx] = '0;
`ifdef AXI_BURST_COUNTER_ERR_EN
            err_d[alloc_idx]   = 1'b0;
`endif
            for (int j = 0; j < MaxTxns; j++) begin
                older_d[j][alloc_idx] = valid_d[j] && (IdxWidth'(j) != alloc_idx);
            end
        end
        occ_d = '0;
        for (int i = 0; i < MaxTxns; i++) begin
            occ_d = occ_d + OccWidth'(valid_d[i]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int i = 0; i < MaxTxns; i++) begin
                id_q[i]    <= '0;
                rem_q[i]   <= '0;
                older_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            id_q    <= id_d;
            rem_q   <= rem_d;
            older_q <= older_d;
        end
    end

`ifdef AXI_BURST_COUNTER_ERR_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    assign occ_o = occ_q;

endmodule
